p3_exec_mc: RTL

Parametrised, multi-cycle successor to the phase-3 execute stage of the SIMPLE datapath. It selects ALU operands, performs single-cycle ALU/shift operations, and performs an iterative WIDTH-cycle unsigned multiply (divide optional). Results go to a registered data register plus an auxiliary high/remainder register, with registered condition codes. It drives a stall line to the phase controller, which holds phase_counter at EXEC_PHASE while stall is high.

---
 rtl/p3_exec_mc.sv | 296 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/p3_exec_mc.sv
`default_nettype none
// ============================================================================
// Module      : p3_exec_mc
// Description : Multi-cycle execute stage. It runs single-cycle ALU/shift ops
//               and an iterative WIDTH-step unsigned multiply. When the macro
//               P3_EXEC_DIV_EN is defined, it also runs a restoring divide.
// Revision    : 1.0 - initial release
// ============================================================================
module p3_exec_mc #(
    parameter int         WIDTH      = 16,
    parameter logic [2:0] EXEC_PHASE = 3'b010
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       phase_counter,
    input  logic [WIDTH-1:0] ar,
    input  logic [WIDTH-1:0] br,
    input  logic [WIDTH-1:0] program_counter_pre,
    input  logic [15:0]      instruction_register,
    input  logic [WIDTH-1:0] inp,
    input  logic [1:0]       op_alu_src_a,
    input  logic [1:0]       op_alu_src_b,
    input  logic [3:0]       op_alu,
    output logic [WIDTH-1:0] data_register,
    output logic [WIDTH-1:0] aux_register,
    output logic [3:0]       cond,
    output logic             stall
);

    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;
    localparam logic [SHW-1:0] c_LAST = SHW'(WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [3:0] c_OP_ADD = 4'b0000;
    localparam logic [3:0] c_OP_SUB = 4'b0001;
    localparam logic [3:0] c_OP_AND = 4'b0010;
    localparam logic [3:0] c_OP_OR  = 4'b0011;
    localparam logic [3:0] c_OP_XOR = 4'b0100;
    localparam logic [3:0] c_OP_CMP = 4'b0101;
    localparam logic [3:0] c_OP_MOV = 4'b0110;
    localparam logic [3:0] c_OP_SLL = 4'b1000;
    localparam logic [3:0] c_OP_SLR = 4'b1001;
    localparam logic [3:0] c_OP_SRL = 4'b1010;
    localparam logic [3:0] c_OP_SRA = 4'b1011;
    localparam logic [3:0] c_OP_MUL = 4'b1100;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_data;
    logic [WIDTH-1:0]   r_aux;
    logic [3:0]         r_cond;
    logic               r_stall;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [SHW-1:0]     r_cnt;

    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic [WIDTH-1:0]   w_imm8;
    logic [WIDTH-1:0]   w_imm4;
    logic [SHW-1:0]     w_shamt;
    logic [WIDTH:0]     w_add;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH:0]     w_shl;
    logic [WIDTH:0]     w_shr;
    logic [WIDTH:0]     w_sra;
    logic [2*WIDTH-1:0] w_rot;
    logic [WIDTH-1:0]   w_res;
    logic [WIDTH-1:0]   w_fsrc;
    logic               w_c;
    logic               w_v;
    logic [3:0]         w_flags;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [3:0]         w_mul_cond;
    logic               w_exec;
    logic               w_unused;

    assign w_exec  = (phase_counter == EXEC_PHASE);
    assign w_imm8  = WIDTH'($signed(instruction_register[7:0]));
    assign w_imm4  = WIDTH'(instruction_register[3:0]);
    assign w_shamt = w_b[SHW-1:0];

    always_comb begin
        w_a = '0;
        case (op_alu_src_a)
            2'd0:    w_a = br;
            2'd1:    w_a = inp;
            2'd2:    w_a = program_counter_pre;
            default: w_a = '0;
        endcase
    end

    always_comb begin
        w_b = '0;
        case (op_alu_src_b)
            2'd0:    w_b = w_imm8;
            2'd1:    w_b = w_imm4;
            2'd2:    w_b = ar;
            default: w_b = '0;
        endcase
    end

    // A guard bit on each shift catches the last bit shifted out; it stays 0 for a zero amount
    assign w_add  = {1'b0, w_a} + {1'b0, w_b};
    assign w_diff = w_a - w_b;
    assign w_shl  = {1'b0, w_a} << w_shamt;
    assign w_shr  = {w_a, 1'b0} >> w_shamt;
    assign w_sra  = (WIDTH+1)'($signed({w_a, 1'b0}) >>> w_shamt);
    assign w_rot  = {w_a, w_a} << w_shamt;

    always_comb begin
        w_res  = '0;
        w_fsrc = '0;
        w_c    = 1'b0;
        w_v    = 1'b0;
        case (op_alu)
            c_OP_ADD: begin
                w_res  = w_add[WIDTH-1:0];
                w_fsrc = w_add[WIDTH-1:0];
                w_c    = w_add[WIDTH];
                w_v    = (w_a[MSB] == w_b[MSB]) && (w_add[MSB] != w_a[MSB]);
            end
            c_OP_SUB, c_OP_CMP: begin
                w_res  = (op_alu == c_OP_CMP) ? w_a : w_diff;
                w_fsrc = w_diff;
                w_c    = (w_a < w_b);
                w_v    = (w_a[MSB] != w_b[MSB]) && (w_diff[MSB] != w_a[MSB]);
            end
            c_OP_AND: begin
                w_res  = w_a & w_b;
                w_fsrc = w_a & w_b;
            end
            c_OP_OR: begin
                w_res  = w_a | w_b;
                w_fsrc = w_a | w_b;
            end
            c_OP_XOR: begin
                w_res  = w_a ^ w_b;
                w_fsrc = w_a ^ w_b;
            end
            c_OP_MOV: begin
                w_res  = w_b;
                w_fsrc = w_b;
            end
            c_OP_SLL: begin
                w_res  = w_shl[WIDTH-1:0];
                w_fsrc = w_shl[WIDTH-1:0];
                w_c    = w_shl[WIDTH];
            end
            c_OP_SLR: begin
                w_res  = w_rot[2*WIDTH-1:WIDTH];
                w_fsrc = w_rot[2*WIDTH-1:WIDTH];
                w_c    = (w_shamt != '0) && w_rot[WIDTH];
            end
            c_OP_SRL: begin
                w_res  = w_shr[WIDTH:1];
                w_fsrc = w_shr[WIDTH:1];
                w_c    = w_shr[0];
            end
            c_OP_SRA: begin
                w_res  = w_sra[WIDTH:1];
                w_fsrc = w_sra[WIDTH:1];
                w_c    = w_sra[0];
            end
            default: begin
                w_res  = '0;
                w_fsrc = '0;
            end
        endcase
    end

    assign w_flags    = {w_fsrc[MSB], (w_fsrc == '0), w_c, w_v};
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_mul_cond = {w_acc_next[MSB], (w_acc_next[WIDTH-1:0] == '0),
                         (w_acc_next[2*WIDTH-1:WIDTH] != '0), 1'b0};
    assign w_unused   = ^{instruction_register[15:8], w_rot[WIDTH-1:0]};

`ifdef P3_EXEC_DIV_EN
    localparam logic [3:0] c_OP_DIV = 4'b1101;

    logic           r_is_div;
    logic [WIDTH:0] w_div_shift;
    logic [WIDTH:0] w_div_trial;
    logic           w_div_ok;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;

    // Restoring step: dividend bits shift out of r_mplier, quotient bits shift in
    assign w_div_shift = {r_acc[WIDTH-1:0], r_mplier[MSB]};
    assign w_div_trial = w_div_shift - {1'b0, r_mcand[WIDTH-1:0]};
    assign w_div_ok    = ~w_div_trial[WIDTH];
    assign w_rem_next  = w_div_ok ? w_div_trial[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
    assign w_quo_next  = {r_mplier[WIDTH-2:0], w_div_ok};
`endif

    always_ff @(negedge clock) begin
        if (!reset) begin
            r_state  <= c_IDLE;
            r_data   <= '0;
            r_aux    <= '0;
            r_cond   <= '0;
            r_stall  <= 1'b0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
`ifdef P3_EXEC_DIV_EN
            r_is_div <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_exec) begin
                        if (op_alu == c_OP_MUL) begin
                            r_mcand  <= {{WIDTH{1'b0}}, w_a};
                            r_mplier <= w_b;
                            r_acc    <= '0;
                            r_cnt    <= '0;
                            r_stall  <= 1'b1;
                            r_state  <= c_BUSY;
`ifdef P3_EXEC_DIV_EN
                            r_is_div <= 1'b0;
                        end else if (op_alu == c_OP_DIV) begin
                            if (w_b == '0) begin
                                r_data  <= '1;
                                r_aux   <= w_a;
                                r_cond  <= 4'b1001;
                                r_state <= c_DONE;
                            end else begin
                                r_mcand  <= {{WIDTH{1'b0}}, w_b};
                                r_mplier <= w_a;
                                r_acc    <= '0;
                                r_cnt    <= '0;
                                r_stall  <= 1'b1;
                                r_is_div <= 1'b1;
                                r_state  <= c_BUSY;
                            end
`endif
                        end else begin
                            r_data  <= w_res;
                            r_cond  <= w_flags;
                            r_state <= c_DONE;
                        end
                    end
                end
                c_BUSY: begin
                    r_cnt <= r_cnt + SHW'(1);
`ifdef P3_EXEC_DIV_EN
                    if (r_is_div) begin
                        r_acc    <= {{WIDTH{1'b0}}, w_rem_next};
                        r_mplier <= w_quo_next;
                        if (r_cnt == c_LAST) begin
                            r_data  <= w_quo_next;
                            r_aux   <= w_rem_next;
                            r_cond  <= {w_quo_next[MSB], (w_quo_next == '0), 2'b00};
                            r_stall <= 1'b0;
                            r_state <= c_DONE;
                        end
                    end else begin
`else
                    begin
`endif
                        r_acc    <= w_acc_next;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        if (r_cnt == c_LAST) begin
                            r_data  <= w_acc_next[WIDTH-1:0];
                            r_aux   <= w_acc_next[2*WIDTH-1:WIDTH];
                            r_cond  <= w_mul_cond;
                            r_stall <= 1'b0;
                            r_state <= c_DONE;
                        end
                    end
                end
                c_DONE: begin
                    // Wait for the controller to leave the execute phase before re-arming
                    if (!w_exec) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign data_register = r_data;
    assign aux_register  = r_aux;
    assign cond          = r_cond;
    assign stall         = r_stall;

endmodule
`default_nettype wire
